// File: rtl/trng_entropy_collector.sv
// trng_entropy_collector: XOR-folded ring-oscillator sampler with
// Von Neumann debias, repetition-count health test and word FIFO.
module trng_entropy_collector #(
  parameter int NUM_OSC    = 4,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_CUTOFF = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_OSC-1:0]            osc_in,
  input  logic                          enable,
  input  logic                          clear,
  input  logic                          debias_en,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          health_fail,
  output logic [15:0]                   bits_dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WORD_W) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    RCT_CUT  = 8'(RCT_CUTOFF);
  localparam logic          PH_A     = 1'b0;
  localparam logic          PH_B     = 1'b1;

  logic [NUM_OSC-1:0] sync1, sync2;
  logic               raw_bit;
  logic               phase, stored, debias_q, debias_chg;
  logic [7:0]         rct_cnt, rct_next;
  logic               last_bit, fail_rise;
  logic               accept, acc_bit;
  logic [WORD_W-1:0]  acc, acc_n, acc_sh, push_data;
  logic [CW-1:0]      bit_cnt, cnt_n;
  logic               push, pop, drop, full, pending, can_push;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [WORD_W-1:0]  mem [FIFO_DEPTH];

  assign raw_bit    = ^sync2;
  assign debias_chg = debias_en != debias_q;
  assign fifo_level = wr_ptr - rd_ptr;
  assign full       = fifo_level == LVL_FULL;
  assign word_valid = (fifo_level != '0) && !health_fail;
  assign word_data  = (fifo_level == '0) ? '0 : mem[rd_ptr[AW-1:0]];
  assign pop        = word_valid && word_ready;
  assign can_push   = !full || pop;
  assign pending    = bit_cnt == CNT_FULL;
  assign acc_sh     = {acc[WORD_W-2:0], acc_bit};
  assign fail_rise  = enable && !health_fail && (rct_next >= RCT_CUT);

  // Two-flop synchroniser per oscillator; clear does not stop it
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
    end
  end

  // Next repetition count on the raw (pre-debias) bit
  always_comb begin
    rct_next = 8'd1;
    if (raw_bit == last_bit)
      rct_next = (rct_cnt == 8'hFF) ? 8'hFF : rct_cnt + 8'd1;
  end

  // Bit acceptance: debias pairs use the first bit of an unequal pair
  always_comb begin
    accept  = 1'b0;
    acc_bit = raw_bit;
    if (enable && !health_fail) begin
      if (debias_en) begin
        accept  = (phase == PH_B) && (stored != raw_bit);
        acc_bit = stored;
      end else begin
        accept = 1'b1;
      end
    end
  end

  // Accumulator and push decision; a full word waits while FIFO is full
  always_comb begin
    push      = 1'b0;
    push_data = acc;
    acc_n     = acc;
    cnt_n     = bit_cnt;
    drop      = 1'b0;
    if (pending) begin
      if (can_push && !health_fail) begin
        push  = 1'b1;
        cnt_n = '0;
        if (accept) begin
          acc_n = acc_sh;
          cnt_n = CW'(1);
        end
      end else if (accept) begin
        drop = 1'b1;
      end
    end else if (accept) begin
      acc_n = acc_sh;
      if (bit_cnt == CNT_FULL - CW'(1)) begin
        if (can_push) begin
          push      = 1'b1;
          push_data = acc_sh;
          cnt_n     = '0;
        end else begin
          cnt_n = CNT_FULL;
        end
      end else begin
        cnt_n = bit_cnt + CW'(1);
      end
    end
  end

  // Debias phase, repetition counter and sticky health flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      phase       <= PH_A;
      stored      <= 1'b0;
      debias_q    <= 1'b0;
      rct_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (!enable || !debias_en || debias_chg)
        phase <= PH_A;
      else
        phase <= (phase == PH_A) ? PH_B : PH_A;
      if (enable && phase == PH_A)
        stored <= raw_bit;
      debias_q <= debias_en;
      if (enable) begin
        rct_cnt  <= rct_next;
        last_bit <= raw_bit;
      end
      if (fail_rise)
        health_fail <= 1'b1;
    end
  end

  // Accumulator state, FIFO pointers and dropped-bit counter
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc          <= '0;
      bit_cnt      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bits_dropped <= '0;
    end else begin
      acc     <= acc_n;
      bit_cnt <= cnt_n;
      if (drop && bits_dropped != 16'hFFFF)
        bits_dropped <= bits_dropped + 16'd1;
      if (fail_rise) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)
          rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are only visible through the pointers
  always_ff @(posedge clk) begin
    if (push && !fail_rise && !rst && !clear)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: tb/tb_trng_entropy_collector.sv
// tb_trng_entropy_collector: directed sequence with random raw bits
// checked each cycle against a queue-based reference model.
module tb_trng_entropy_collector;

  logic        clk = 1'b0;
  logic        rst, enable, clear, debias_en, word_ready;
  logic [3:0]  osc_in;
  logic [31:0] word_data;
  logic        word_valid, health_fail;
  logic [2:0]  fifo_level;
  logic [15:0] bits_dropped;

  int total = 0;
  int bad   = 0;

  trng_entropy_collector #(
    .NUM_OSC(4), .WORD_W(32), .FIFO_DEPTH(4), .RCT_CUTOFF(32)
  ) dut (
    .clk(clk), .rst(rst), .osc_in(osc_in), .enable(enable),
    .clear(clear), .debias_en(debias_en), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready),
    .fifo_level(fifo_level), .health_fail(health_fail),
    .bits_dropped(bits_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // reference model state
  int          m_cnt, m_drop;
  bit          m_last, m_hf, m_ph, m_st, m_dbq;
  bit          bits[$];
  logic [31:0] q[$];
  // input pipeline: raw bit and enable line up 2 cycles later
  bit          b_d0, b_d1, en_d0, en_d1;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_drop = 0; m_last = 0; m_hf = 0;
    m_ph = 0; m_st = 0; m_dbq = 0;
    bits.delete();
    q.delete();
  endtask

  function automatic logic [31:0] pack();
    logic [31:0] w = '0;
    foreach (bits[i]) w = {w[30:0], bits[i]};
    return w;
  endfunction

  task automatic model_step(bit raw, bit en, bit rdy, bit clr, bit dbe);
    bit pop, ok, ab, space, rise;
    if (clr) begin
      m_reset();
      return;
    end
    pop = (q.size() > 0) && !m_hf && rdy;
    ok = 0; ab = 0;
    if (en && !m_hf) begin
      if (dbe) begin
        if (m_ph && (m_st != raw)) begin ok = 1; ab = m_st; end
      end else begin
        ok = 1; ab = raw;
      end
    end
    if (en && !m_ph) m_st = raw;
    if (!en || !dbe || (dbe != m_dbq)) m_ph = 0;
    else m_ph = !m_ph;
    m_dbq = dbe;
    rise = 0;
    if (en) begin
      if (raw == m_last) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      else m_cnt = 1;
      m_last = raw;
      if (!m_hf && m_cnt >= 32) rise = 1;
    end
    space = (q.size() < 4) || pop;
    if (pop) void'(q.pop_front());
    if (bits.size() == 32) begin
      if (space && !m_hf) begin
        q.push_back(pack());
        bits.delete();
        if (ok) bits.push_back(ab);
      end else if (ok && m_drop < 65535) begin
        m_drop++;
      end
    end else if (ok) begin
      bits.push_back(ab);
      if (bits.size() == 32 && space) begin
        q.push_back(pack());
        bits.delete();
      end
    end
    if (rise) begin
      q.delete();
      m_hf = 1;
    end
  endtask

  function automatic logic [3:0] par(bit b);
    logic [3:0] v = 4'($urandom_range(0, 15));
    if ((^v) != b) v[0] = ~v[0];
    return v;
  endfunction

  task automatic cyc(bit b, bit en, bit rdy, bit clr);
    logic [31:0] ed;
    @(posedge clk); #1;
    ed = (q.size() > 0) ? q[0] : 32'h0;
    chk("valid", 64'(word_valid), 64'((q.size() > 0) && !m_hf));
    chk("level", 64'(fifo_level), 64'(q.size()));
    chk("data", 64'(word_data), 64'(ed));
    chk("hfail", 64'(health_fail), 64'(m_hf));
    chk("dropped", 64'(bits_dropped), 64'(m_drop));
    osc_in     = par(b);
    word_ready = rdy;
    clear      = clr;
    enable     = en_d1;
    model_step(b_d1, en_d1, rdy, clr, debias_en);
    b_d1 = b_d0; b_d0 = b;
    en_d1 = en_d0; en_d0 = en;
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic rnd_bits(int n);
    for (int i = 0; i < n; i++)
      cyc(bit'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
  endtask

  bit pat [10] = '{0, 1, 1, 0, 1, 1, 0, 0, 1, 0};

  initial begin
    rst = 1; enable = 0; clear = 0; debias_en = 0;
    word_ready = 0; osc_in = '0;
    b_d0 = 0; b_d1 = 0; en_d0 = 0; en_d1 = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_hfail", 64'(health_fail), 64'd0);
    chk("rst_drop", 64'(bits_dropped), 64'd0);
    chk("rst_data", 64'(word_data), 64'd0);
    rst = 0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // raw mode, alternating 1,0
    for (int i = 0; i < 32; i++) cyc(i % 2 == 0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("raw_level", 64'(fifo_level), 64'd1);
    chk("raw_word", 64'(word_data), 64'hAAAAAAAA);
    chk("raw_valid", 64'(word_valid), 64'd1);
    idle(2, 1'b1);

    // Von Neumann debias
    debias_en = 1;
    idle(2, 1'b0);
    for (int r = 0; r < 10; r++)
      for (int j = 0; j < 10; j++) cyc(pat[j], 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) cyc(pat[j], 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("vn_level", 64'(fifo_level), 64'd1);
    chk("vn_word", 64'(word_data), 64'h6DB6DB6D);
    idle(2, 1'b1);

    // FIFO full with dropped bits
    debias_en = 0;
    idle(2, 1'b0);
    rnd_bits(5 * 32 + 10);
    idle(3, 1'b0);
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_drop", 64'(bits_dropped), 64'd10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("popush_level", 64'(fifo_level), 64'd4);
    chk("popush_drop", 64'(bits_dropped), 64'd10);
    idle(6, 1'b1);
    chk("drain_level", 64'(fifo_level), 64'd0);

    // health test trip, flush, clear and resume
    for (int i = 0; i < 32; i++) cyc(i % 2 == 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    chk("hf_set", 64'(health_fail), 64'd1);
    chk("hf_level", 64'(fifo_level), 64'd0);
    chk("hf_valid", 64'(word_valid), 64'd0);
    idle(2, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("hf_clear", 64'(health_fail), 64'd0);
    rnd_bits(32);
    idle(3, 1'b0);
    chk("resume_level", 64'(fifo_level), 64'd1);
    chk("resume_valid", 64'(word_valid), 64'd1);
    idle(2, 1'b1);

    // clear in the middle of a word with words queued
    rnd_bits(2 * 32 + 17);
    idle(3, 1'b0);
    chk("mid_level", 64'(fifo_level), 64'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    idle(1, 1'b0);
    chk("clr_level", 64'(fifo_level), 64'd0);
    chk("clr_valid", 64'(word_valid), 64'd0);
    rnd_bits(31);
    idle(3, 1'b0);
    chk("clr_31", 64'(fifo_level), 64'd0);
    rnd_bits(1);
    idle(3, 1'b0);
    chk("clr_32", 64'(fifo_level), 64'd1);
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trng_entropy_collector.md
Name: trng_entropy_collector

Overview:
Parametrised successor to the single-shot TRNG sampler. It takes NUM_OSC free-running ring-oscillator outputs from the ring_osc bank, synchronises them and XOR-folds them into one raw bit per cycle. It then applies an optional Von Neumann debiaser and a continuous repetition-count health test, and packs the accepted bits into WORD_W-bit words. Completed words go into a small FIFO that is drained over a valid/ready stream toward the AXI register interface. The host reads whole words instead of triggering bit by bit.

Parameters:
NUM_OSC, 4, number of oscillator inputs XOR-folded into the raw bit (1..16).
WORD_W, 32, output word width in bits (8..64).
FIFO_DEPTH, 4, number of words the output FIFO holds (power of two, >=2).
RCT_CUTOFF, 32, run length of identical raw bits that trips the health failure (2..255).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
osc_in  in  NUM_OSC  asynchronous ring-oscillator outputs.
enable  in  1  collection enable.
clear  in  1  synchronous soft clear (pulse or level).
debias_en  in  1  1 = Von Neumann pairs, 0 = every raw bit accepted.
word_data  out  WORD_W  FIFO head word.
word_valid  out  1  FIFO non-empty and no health failure.
word_ready  in  1  consumer accepts word_data when word_valid=1.
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently stored.
health_fail  out  1  sticky repetition-count failure flag.
bits_dropped  out  16  saturating count of accepted bits discarded because the FIFO was full.

Behaviour:
- Reset (rst=1, sampled on clk): the following are all cleared to 0: sync flops, pair phase, accumulator, bit counter, RCT counter and last-bit register, FIFO pointers, health_fail, bits_dropped. Outputs: word_valid=0, fifo_level=0, word_data=0.
- clear=1 has the same effect as rst, except the sync flops keep running. rst has priority over clear, and clear has priority over all other activity in the same cycle.
- Synchroniser: a 2-flop chain on each osc_in bit runs every cycle regardless of enable. raw_bit = XOR of the second-stage bits. Latency from osc_in to raw_bit is 2 cycles.
- When enable=0: no bits are accepted, the RCT counter holds, and the pair phase is reset to "A". FIFO reads still work.
- Debias (debias_en=1), per enabled cycle:
  - Phase A stores raw_bit.
  - Phase B compares the stored bit with raw_bit. 01 accepts 0. 10 accepts 1. 00 and 11 are discarded.
  - The phase toggles every enabled cycle.
- Debias off (debias_en=0): raw_bit is accepted every enabled cycle.
- Changing debias_en resets the phase to A on the next cycle.
- Health test (RCT): evaluated on every enabled cycle, on raw_bit before debiasing.
  - If raw_bit equals the last bit, the counter increments (saturating at 255). Otherwise the counter is set to 1.
  - When the counter reaches RCT_CUTOFF, health_fail is set on the next cycle. It stays set until rst or clear.
  - While health_fail=1: no bits are accepted, word_valid is forced 0, FIFO pops are ignored, and FIFO contents are flushed on the cycle health_fail rises.
- Accumulator:
  - An accepted bit shifts in at the LSB: acc <= {acc[WORD_W-2:0], bit}. The bit counter increments.
  - When the counter reaches WORD_W, the word is pushed into the FIFO in that same cycle and the counter returns to 0. The first accepted bit ends up in the MSB.
- FIFO full at push time: the word is not written, the counter stays at WORD_W, and the accumulator holds. Each further accepted bit increments bits_dropped (saturating at 16'hFFFF). The pending word is pushed on the first cycle a slot is free.
- Pop occurs when word_valid & word_ready. A simultaneous push and pop is legal at any level, including full (the pop frees the slot in the same cycle) and empty (the FIFO is not bypassed, so word_valid rises the next cycle).
- fifo_level updates one cycle after the push or pop. Pointers wrap modulo FIFO_DEPTH.
- word_data shows the head entry combinationally from the FIFO storage. It is 0 when empty.
- Latency from the last accepted bit of a word to word_valid=1 is 1 cycle when the FIFO has space.

Test Plan:
1. Reset/idle: rst for 3 cycles, enable=0 -> word_valid=0, fifo_level=0, health_fail=0, bits_dropped=0.
2. Raw mode, WORD_W=32, debias_en=0: drive the raw_bit sequence alternating 1,0 for 32 enabled cycles -> one word 32'hAAAAAAAA, word_valid rises 1 cycle after the 32nd accepted bit, fifo_level=1.
3. Debias: raw pairs 01,10,11,00,10 repeated -> only 0,1,1 accepted per 5 pairs. After 32 accepted bits the word equals 32'h6DB6DB6D (repeating 011 pattern); discarded pairs do not advance the counter.
4. FIFO full, FIFO_DEPTH=4: hold word_ready=0 and stream 5 words plus 10 bits -> fifo_level=4, bits_dropped=10. Assert word_ready for 1 cycle -> pending 5th word pushed in the same cycle as the pop, fifo_level stays 4.
5. Health: constant raw_bit=1 for RCT_CUTOFF=32 enabled cycles -> health_fail=1 on the next cycle, FIFO flushed (fifo_level=0), word_valid=0. Pulse clear -> health_fail=0, collection resumes.
6. Mid-operation clear: after 17 accepted bits and 2 words queued, assert clear with word_ready=1 -> same cycle pop suppressed, next cycle fifo_level=0 and the next word needs a full 32 new bits.
